// File: rtl/pipelined_addsub_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_addsub_pkg
//   Shared definitions for the pipelined adder/subtractor:
//   - op-mode encoding (ADD = 0, SUB = 1)
//   - chunk width derivation (CHUNK = WIDTH / STAGES)
//   - divisibility check used at elaboration time by the top level
// -----------------------------------------------------------------------------
package pipelined_addsub_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_mode_e;

   // Bits handled by each pipeline stage.
   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

   // True when the operand width splits evenly into the requested stages.
   function automatic bit width_divisible(input int width, input int stages);
      return (stages > 0) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/addsub_chunk.sv
// -----------------------------------------------------------------------------
// addsub_chunk
//   Combinational CHUNK-bit ripple adder built from full_adder cells. Operand
//   inversion for subtraction happens upstream; this block only adds.
// Ports:
//   a, b   in  [CHUNK-1:0] chunk operands
//   cin    in  carry into the chunk LSB
//   s      out [CHUNK-1:0] chunk sum
//   cout   out carry out of the chunk MSB
//   c_msb  out carry into the chunk MSB (overflow detection on the top chunk)
// -----------------------------------------------------------------------------
module addsub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   logic [CHUNK:0] carry;

   assign carry[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < CHUNK; gi++) begin : g_bit
         full_adder u_fa (
            .a    (a[gi]),
            .b    (b[gi]),
            .cin  (carry[gi]),
            .s    (s[gi]),
            .cout (carry[gi+1])
         );
      end
   endgenerate

   assign cout  = carry[CHUNK];
   assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Single-bit full adder cell, the building block of the ripple chunks.
// Ports:
//   a, b  in  operand bits
//   cin   in  carry in
//   s     out sum bit
//   cout  out carry out
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
//   Pipelined ripple-carry adder/subtractor. The operands are split into
//   STAGES chunks of CHUNK bits; stage k adds chunk k and registers its carry
//   for stage k+1. Operand chunks not yet consumed travel in skew registers,
//   finished sum chunks accumulate in de-skew registers, so one transaction's
//   result leaves the last stage complete in a single beat.
//   All stages advance together (adv) whenever the output slot is empty or
//   being accepted; otherwise the whole pipe holds.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  operands accepted this cycle (= adv)
//   a, b       in   [WIDTH-1:0] operands
//   cin        in   carry in (add only)
//   sub        in   0: a+b+cin, 1: a-b
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   sum        out  [WIDTH-1:0] result mod 2^WIDTH
//   cout       out  carry out of MSB (subtract: 1 = no borrow)
//   ovf        out  signed overflow
// -----------------------------------------------------------------------------
module pipelined_addsub
   import pipelined_addsub_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CHUNK = chunk_width(WIDTH, STAGES);

   generate
      if (!width_divisible(WIDTH, STAGES)) begin : g_width_check
         $error("pipelined_addsub: WIDTH (%0d) must be divisible by STAGES (%0d)", WIDTH, STAGES);
      end
   endgenerate

   op_mode_e         op;
   logic [WIDTH-1:0] b_eff;
   logic             carry0;
   logic             adv;

   assign op     = sub ? OP_SUB : OP_ADD;
   // Subtraction as a + ~b + 1: invert once at the input, force the carry in.
   assign b_eff  = (op == OP_SUB) ? ~b : b;
   assign carry0 = (op == OP_SUB) ? 1'b1 : cin;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         // DONE: sum bits completed before this stage; REM: operand bits still
         // pending on entry to this stage (this chunk and everything above it).
         localparam int DONE = gi * CHUNK;
         localparam int REM  = WIDTH - DONE;

         logic [REM-1:0]        a_in;
         logic [REM-1:0]        b_in;
         logic                  carry_in;
         logic                  valid_in;
         logic [DONE+CHUNK-1:0] sum_src;

         logic [CHUNK-1:0]      chunk_sum;
         logic                  chunk_cout;
         logic                  chunk_cmsb;

         logic [DONE+CHUNK-1:0] sum_d,   sum_q;
         logic                  carry_d, carry_q;
         logic                  valid_d, valid_q;

         if (gi == 0) begin : g_first
            assign a_in     = a;
            assign b_in     = b_eff;
            assign carry_in = carry0;
            assign valid_in = in_valid;
            assign sum_src  = chunk_sum;
         end else begin : g_next
            assign a_in     = g_stage[gi-1].g_skew.a_rest_q;
            assign b_in     = g_stage[gi-1].g_skew.b_rest_q;
            assign carry_in = g_stage[gi-1].carry_q;
            assign valid_in = g_stage[gi-1].valid_q;
            // New chunk lands above the already-finished lower chunks.
            assign sum_src  = {chunk_sum, g_stage[gi-1].sum_q};
         end

         addsub_chunk #(
            .CHUNK (CHUNK)
         ) u_chunk (
            .a     (a_in[CHUNK-1:0]),
            .b     (b_in[CHUNK-1:0]),
            .cin   (carry_in),
            .s     (chunk_sum),
            .cout  (chunk_cout),
            .c_msb (chunk_cmsb)
         );

         always_comb begin
            valid_d = valid_q;
            carry_d = carry_q;
            sum_d   = sum_q;
            if (adv) begin
               valid_d = valid_in;
               carry_d = chunk_cout;
               sum_d   = sum_src;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_q <= 1'b0;
               carry_q <= 1'b0;
               sum_q   <= '0;
            end else begin
               valid_q <= valid_d;
               carry_q <= carry_d;
               sum_q   <= sum_d;
            end
         end

         if (gi < STAGES - 1) begin : g_skew
            // Operand chunks above this one, delayed for the later stages.
            logic [REM-CHUNK-1:0] a_rest_d, a_rest_q;
            logic [REM-CHUNK-1:0] b_rest_d, b_rest_q;
            // Only the top chunk's MSB carry matters for overflow.
            logic                 cmsb_unused;

            assign cmsb_unused = chunk_cmsb;

            always_comb begin
               a_rest_d = a_rest_q;
               b_rest_d = b_rest_q;
               if (adv) begin
                  a_rest_d = a_in[REM-1:CHUNK];
                  b_rest_d = b_in[REM-1:CHUNK];
               end
            end

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  a_rest_q <= '0;
                  b_rest_q <= '0;
               end else begin
                  a_rest_q <= a_rest_d;
                  b_rest_q <= b_rest_d;
               end
            end
         end else begin : g_last
            logic ovf_d, ovf_q;

            // Signed overflow: carry into the MSB differs from carry out.
            always_comb begin
               ovf_d = ovf_q;
               if (adv) begin
                  ovf_d = chunk_cmsb ^ chunk_cout;
               end
            end

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  ovf_q <= 1'b0;
               end else begin
                  ovf_q <= ovf_d;
               end
            end
         end
      end
   endgenerate

   assign out_valid = g_stage[STAGES-1].valid_q;
   assign sum       = g_stage[STAGES-1].sum_q;
   assign cout      = g_stage[STAGES-1].carry_q;
   assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
